// File: rtl/run_result_reader_if.sv
// Accelerator memory-mapped read port plus result output stream for run_result_reader.
// master: the reader side; slave: the accelerator / stream-consumer side.
interface run_result_reader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 2
);
  logic                  acc_run;
  logic                  acc_done;
  logic                  acc_valid;
  logic [ADDR_W-1:0]     acc_addr;
  logic [DATA_W/8-1:0]   acc_wstrb;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  acc_ready;
  logic [DATA_W-1:0]     acc_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_W-1:0]     m_data;
  logic                  m_last;

  modport master (
    output acc_run, acc_valid, acc_addr, acc_wstrb, acc_wdata, m_valid, m_data, m_last,
    input  acc_done, acc_ready, acc_rdata, m_ready
  );

  modport slave (
    input  acc_run, acc_valid, acc_addr, acc_wstrb, acc_wdata, m_valid, m_data, m_last,
    output acc_done, acc_ready, acc_rdata, m_ready
  );
endinterface

// File: rtl/run_result_reader.sv
// Launches one accelerator run, reads NUM_UNITS result words into an output FIFO.
// Optional RUN_RESULT_READER_CNT_EN appends a WAIT-cycle count word to each run.
module run_result_reader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  run_result_reader_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StWait, StRead} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  logic              full, acc_fire, unit_last, push, pop, push_last;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W:0]   head;

`ifdef RUN_RESULT_READER_CNT_EN
  logic [DATA_W-1:0] cnt_q;
  logic              cnt_phase_q;
  logic              cnt_push;
`endif

  always_comb begin
    full          = (count_q == CntW'(FIFO_DEPTH));
    unit_last     = (addr_q == ADDR_W'(NUM_UNITS - 1));
    bus.acc_valid = (state_q == StRead) && !full;
`ifdef RUN_RESULT_READER_CNT_EN
    bus.acc_valid = bus.acc_valid && !cnt_phase_q;
    acc_fire      = bus.acc_valid && bus.acc_ready;
    cnt_push      = (state_q == StRead) && cnt_phase_q && !full;
    push          = acc_fire || cnt_push;
    push_data     = cnt_push ? cnt_q : bus.acc_rdata;
    push_last     = cnt_push;
`else
    acc_fire      = bus.acc_valid && bus.acc_ready;
    push          = acc_fire;
    push_data     = bus.acc_rdata;
    push_last     = unit_last;
`endif
    pop           = bus.m_valid && bus.m_ready;
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.m_valid   = (count_q != '0);
  // Gate the head so the stream reads as zero whenever the FIFO is empty.
  assign bus.m_data    = bus.m_valid ? head[DATA_W-1:0] : '0;
  assign bus.m_last    = bus.m_valid & head[DATA_W];
  assign bus.acc_run   = (state_q == StRun);
  assign bus.acc_addr  = addr_q;
  assign bus.acc_wstrb = '0;
  assign bus.acc_wdata = '0;
  assign busy          = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
`ifdef RUN_RESULT_READER_CNT_EN
      cnt_q       <= '0;
      cnt_phase_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: if (start) state_q <= StRun;
        StRun: begin
          state_q <= StWait;
          addr_q  <= '0;
`ifdef RUN_RESULT_READER_CNT_EN
          cnt_q   <= '0;
`endif
        end
        StWait: begin
          if (bus.acc_done) state_q <= StRead;
`ifdef RUN_RESULT_READER_CNT_EN
          // Counts the WAIT cycles spent before done is seen.
          else cnt_q <= cnt_q + DATA_W'(1);
`endif
        end
        StRead: begin
          if (acc_fire) begin
            if (unit_last) begin
              addr_q <= '0;
`ifdef RUN_RESULT_READER_CNT_EN
              cnt_phase_q <= 1'b1;
`else
              state_q <= StIdle;
`endif
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
`ifdef RUN_RESULT_READER_CNT_EN
          if (cnt_push) begin
            cnt_phase_q <= 1'b0;
            state_q     <= StIdle;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, push_data};
  end

endmodule

// File: tb/tb_run_result_reader.sv
// Scoreboard bench for run_result_reader: a behavioural accelerator model feeds reads,
// expected words are queued at issue time and checked by a decoupled stream monitor.
module tb_run_result_reader;
  localparam int unsigned DW = 32;
  localparam int unsigned NU = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy;

  run_result_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  run_result_reader #(
    .DATA_W(DW), .NUM_UNITS(NU), .ADDR_W(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail = 0;
  int   exp_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accelerator model: done rises done_dly cycles after the run pulse, ready after rdy_dly.
  int unsigned done_dly = 5;
  int unsigned rdy_dly = 0;
  int unsigned dcnt = 0;
  int unsigned wcnt = 0;
  int          run_id = -1;
  logic        armed = 1'b0;

  always @(posedge clk) begin
    if (bus.acc_run) run_id <= run_id + 1;
    if (!rst) begin
      armed        <= 1'b0;
      bus.acc_done <= 1'b0;
    end else if (bus.acc_run) begin
      dcnt         <= 0;
      armed        <= 1'b1;
      bus.acc_done <= 1'b0;
    end else if (armed) begin
      if (dcnt + 1 >= done_dly) begin
        bus.acc_done <= 1'b1;
        armed        <= 1'b0;
      end
      dcnt <= dcnt + 1;
    end
    if (rst && bus.acc_valid && !bus.acc_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign bus.acc_ready = bus.acc_valid && (wcnt >= rdy_dly);
  assign bus.acc_rdata = DW'(run_id * 256 + (int'(bus.acc_addr) + 1) * 17);

  // Stream monitor: pops and compares each accepted output word.
  always @(negedge clk) begin
    if (rst && bus.m_valid && bus.m_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected none", bus.m_data);
      end else begin
        e_mon = q.pop_front();
        check("m_data", 64'(bus.m_data), 64'(e_mon.data));
        check("m_last", 64'(bus.m_last), 64'(e_mon.last));
      end
    end
  end

  // Read-port monitor: address/valid hold under back-pressure, pulse and push counts.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            pulses = 0;
  int            pushes = 0;

  always @(negedge clk) begin
    if (rst && prev_stall) begin
      check("valid_hold", 64'(bus.acc_valid), 64'd1);
      check("addr_hold", 64'(bus.acc_addr), 64'(prev_addr));
    end
    prev_stall = rst && bus.acc_valid && !bus.acc_ready;
    prev_addr  = bus.acc_addr;
    if (rst && bus.acc_run) pulses++;
    if (rst && bus.acc_valid && bus.acc_ready) pushes++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic issue_run();
    exp_t e;
    for (int a = 0; a < int'(NU); a++) begin
      e.data = DW'(exp_run * 256 + (a + 1) * 17);
`ifdef RUN_RESULT_READER_CNT_EN
      e.last = 1'b0;
`else
      e.last = (a == int'(NU) - 1);
`endif
      q.push_back(e);
    end
`ifdef RUN_RESULT_READER_CNT_EN
    e.data = DW'(done_dly);
    e.last = 1'b1;
    q.push_back(e);
`endif
    exp_run++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, k;
    bus.m_ready = 1'b0;
    tick(3);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_acc_run",   64'(bus.acc_run),   64'd0);
    check("rst_acc_valid", 64'(bus.acc_valid), 64'd0);
    check("rst_acc_addr",  64'(bus.acc_addr),  64'd0);
    check("rst_m_valid",   64'(bus.m_valid),   64'd0);
    check("rst_m_last",    64'(bus.m_last),    64'd0);
    check("rst_m_data",    64'(bus.m_data),    64'd0);
    check("rst_wstrb",     64'(bus.acc_wstrb), 64'd0);
    rst = 1'b1;
    tick(2);

    // Basic run with a free-flowing stream.
    bus.m_ready = 1'b1;
    p0 = pulses;
    issue_run();
    do_start();
    check("busy_on_start", 64'(busy), 64'd1);
    wait_idle("basic_idle", 100);
    wait_drain("basic_drain", 50);
    check("basic_pulses", 64'(pulses - p0), 64'd1);
    check("basic_wdata", 64'(bus.acc_wdata), 64'd0);

    // Slow accelerator ready: address must hold while waiting.
    rdy_dly = 3;
    s0 = pushes;
    issue_run();
    do_start();
    wait_idle("slow_idle", 200);
    check("slow_pushes", 64'(pushes - s0), 64'd4);
    wait_drain("slow_drain", 50);
    rdy_dly = 0;

    // Second start during WAIT is ignored.
    p0 = pulses;
    issue_run();
    do_start();
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("wait_busy", 64'(busy), 64'd1);
    wait_idle("dup_idle", 100);
    wait_drain("dup_drain", 50);
    tick(3);
    check("dup_pulses", 64'(pulses - p0), 64'd1);

    // Back-pressure: FIFO fills, next run stalls, nothing is lost.
    bus.m_ready = 1'b0;
    issue_run();
    do_start();
    wait_idle("bp_run1_idle", 100);
    check("bp_full_valid", 64'(bus.m_valid), 64'd1);
    issue_run();
    do_start();
    s0 = pushes;
    tick(20);
    check("bp_stall_busy", 64'(busy), 64'd1);
    check("bp_stall_valid", 64'(bus.acc_valid), 64'd0);
    check("bp_stall_pushes", 64'(pushes - s0), 64'd0);
    bus.m_ready = 1'b1;
    wait_idle("bp_run2_idle", 100);
    issue_run();
    do_start();
    wait_idle("bp_run3_idle", 100);
    wait_drain("bp_drain", 100);

    // Reset in the middle of READ abandons the run.
    bus.m_ready = 1'b0;
    issue_run();
    do_start();
    k = 0;
    while (!(bus.acc_valid && bus.acc_addr == AW'(2)) && k < 100) begin
      tick(1);
      k++;
    end
    check("reach_addr2", 64'(k < 100), 64'd1);
    rst = 1'b0;
    tick(1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("mid_rst_acc_valid", 64'(bus.acc_valid), 64'd0);
    rst = 1'b1;
    q.delete();
    tick(5);
    check("post_rst_acc_valid", 64'(bus.acc_valid), 64'd0);
    bus.m_ready = 1'b1;
    issue_run();
    do_start();
    wait_idle("post_rst_idle", 100);
    wait_drain("post_rst_drain", 50);

`ifdef RUN_RESULT_READER_CNT_EN
    // Cycle-count word after seven WAIT cycles.
    done_dly = 7;
    issue_run();
    do_start();
    wait_idle("cnt_idle", 100);
    wait_drain("cnt_drain", 50);
    done_dly = 5;
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/run_result_reader.md
RUN_RESULT_READER -- requirements
Module: run_result_reader

Interface
REQ-001 Parameter DATA_W, default 32: data word width of accelerator read port and output stream.
REQ-002 Parameter NUM_UNITS, default 4: number of memory-mapped result units read per run (addresses 0..NUM_UNITS-1).
REQ-003 Parameter ADDR_W, default 2: width of acc_addr; SHALL satisfy 2**ADDR_W >= NUM_UNITS.
REQ-004 Parameter FIFO_DEPTH, default 8: output FIFO entries, power of two, >= 2.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-007 start  in  1  one-cycle request to launch one accelerator run.
REQ-008 busy  out  1  high from accepted start until the last result word is pushed into the FIFO.
REQ-009 acc_run  out  1  run pulse to the accelerator.
REQ-010 acc_done  in  1  accelerator completion level.
REQ-011 acc_valid  out  1  accelerator memory-mapped request valid.
REQ-012 acc_addr  out  ADDR_W  accelerator unit address.
REQ-013 acc_wstrb  out  DATA_W/8  write strobes, tied to zero (read-only master).
REQ-014 acc_wdata  out  DATA_W  write data, tied to zero.
REQ-015 acc_ready  in  1  accelerator request complete; acc_rdata valid the same cycle.
REQ-016 acc_rdata  in  DATA_W  accelerator read data.
REQ-017 m_valid / m_ready  out / in  1 / 1  output stream handshake; transfer when both high.
REQ-018 m_data  out  DATA_W  FIFO head word.
REQ-019 m_last  out  1  high on the final word of a run's result set.

Function
REQ-020 FSM states IDLE, RUN, WAIT, READ; IDLE->RUN on start; RUN->WAIT after exactly one cycle; WAIT->READ on acc_done=1 sampled no earlier than the cycle after RUN; READ->IDLE on acceptance of the last address.
REQ-021 acc_run SHALL be 1 in RUN only (one-cycle pulse); start SHALL be ignored when busy=1.
REQ-022 In READ, acc_valid SHALL be 1 only while FIFO count < FIFO_DEPTH; acc_addr starts at 0, holds stable while acc_valid=1 and acc_ready=0, increments by 1 on each acc_valid&acc_ready.
REQ-023 On acc_valid&acc_ready, acc_rdata SHALL be pushed into the FIFO that cycle, tagged last=1 when acc_addr == NUM_UNITS-1.
REQ-024 FIFO: circular, pointers wrap modulo FIFO_DEPTH; m_valid = (count != 0); m_data/m_last from head with zero-cycle fall-through after write (first word visible cycle after push).
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push is never performed when full (guaranteed by REQ-022); pop on empty is impossible since m_valid=0.
REQ-026 busy SHALL drop the cycle after the last push; a new start is accepted in IDLE even if the FIFO still holds words from the previous run.
REQ-027 Minimum latency start -> first m_valid: 1 (RUN) + accelerator done delay + 1 (read) + 1 (FIFO) cycles.

Reset
REQ-028 On rst=0 at a clock edge: FSM to IDLE, FIFO emptied, acc_addr=0; outputs busy=0, acc_run=0, acc_valid=0, m_valid=0, m_last=0, m_data=0.
REQ-029 Reset mid-run SHALL abandon the run immediately; no further acc_valid until a new start.

Configuration
REQ-030 Macro RUN_RESULT_READER_CNT_EN: when defined, a DATA_W cycle counter cleared in RUN and incremented each WAIT cycle is pushed as an extra word after unit NUM_UNITS-1; that word carries last=1 and the unit word does not.
REQ-031 Without RUN_RESULT_READER_CNT_EN: exactly NUM_UNITS words per run, no counter logic.

Verification
REQ-032 start, acc_done rises 5 cycles after acc_run, acc_ready same-cycle, rdata 0x11,0x22,0x33,0x44, m_ready=1 -> m_data 0x11..0x44 in order, m_last only on 0x44, one acc_run pulse.
REQ-033 m_ready=0 held, FIFO_DEPTH=4, three back-to-back runs -> acc_valid stalls at count=4, no data lost; release m_ready -> 12 words in order, m_last on words 4, 8, 12.
REQ-034 acc_ready delayed 3 cycles per request -> acc_addr held stable while waiting; exactly 4 pushes.
REQ-035 start asserted again during WAIT -> ignored; exactly one acc_run pulse and 4 words.
REQ-036 rst=0 asserted during READ at addr 2 -> next cycle busy=0, m_valid=0, acc_valid=0; subsequent start yields a clean 4-word run from addr 0.
REQ-037 With RUN_RESULT_READER_CNT_EN, acc_done after 7 WAIT cycles -> fifth word = 7 with m_last=1, fourth word m_last=0.
